// File: rtl/restoring_divider.sv
// Sequential unsigned restoring divider: one shift/subtract step per clock,
// with registered quotient/remainder/div_by_zero qualified by a done pulse.
module restoring_divider #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t           state_q;
    logic [WIDTH:0]   r_q;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] m_q;
    logic [CW-1:0]    cnt_q;
    logic             dz_pend_q;
    logic [WIDTH-1:0] quotient_q;
    logic [WIDTH-1:0] remainder_q;
    logic             dbz_q;
    logic             busy_q;
    logic             done_q;

    logic [WIDTH:0]   r_sh;
    logic [WIDTH:0]   t;
    logic [WIDTH:0]   r_d;
    logic [WIDTH-1:0] q_d;

    // One restoring step: shift {R,Q} left, trial-subtract M, keep or restore.
    always_comb begin
        r_sh = (r_q << 1) | {{WIDTH{1'b0}}, q_q[WIDTH-1]};
        t    = r_sh - {1'b0, m_q};
        r_d  = t[WIDTH] ? r_sh : t;
        q_d  = {q_q[WIDTH-2:0], ~t[WIDTH]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            r_q         <= '0;
            q_q         <= '0;
            m_q         <= '0;
            cnt_q       <= '0;
            dz_pend_q   <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            dz_pend_q <= 1'b0;

            // Divide-by-zero completes one edge after acceptance; the dividend
            // was parked in Q, which a new start may reload on this same edge.
            if (dz_pend_q) begin
                quotient_q  <= '1;
                remainder_q <= q_q;
                dbz_q       <= 1'b1;
                done_q      <= 1'b1;
            end

            case (state_q)
                IDLE: begin
                    if (start) begin
                        q_q <= dividend;
                        if (divisor == '0) begin
                            dz_pend_q <= 1'b1;
                        end else begin
                            m_q     <= divisor;
                            r_q     <= '0;
                            cnt_q   <= CW'(WIDTH);
                            busy_q  <= 1'b1;
                            state_q <= RUN;
                        end
                    end
                end
                RUN: begin
                    r_q   <= r_d;
                    q_q   <= q_d;
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        quotient_q  <= q_d;
                        remainder_q <= r_d[WIDTH-1:0];
                        dbz_q       <= 1'b0;
                        done_q      <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule
